// File: rtl/btn_conv_sequencer.sv
// Debounced two-button controller sequencing 4-bit binary<->Gray conversions.
// Result is latched onto led only when a conversion completes.
module btn_conv_sequencer #(
   parameter int WIDTH     = 4,
   parameter int DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             btn_rst_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn_b2g,
   input  logic             btn_g2b,
   output logic [WIDTH-1:0] led,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_B2G_CALC, S_G2B_SHIFT, S_DONE
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       btn_raw, sync1, sync2, db_level, db_rise, pend, pend_nx;
   logic [CNT_W-1:0] db_cnt [2];
   logic             op_g2b;
   logic [WIDTH-1:0] operand, result, result_nx, result_shr;
   logic [IDX_W-1:0] idx;

   // Bit 0 carries the b2g button, bit 1 the g2b button.
   assign btn_raw = {btn_g2b, btn_b2g};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         db_level <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db_level[i]) begin
               if (db_cnt[i] == CNT_LAST) begin
                  db_level[i] <= sync2[i];
                  db_cnt[i]   <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + CNT_W'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // A rise is flagged on the same edge the debounced level flips to 1.
   always_comb begin
      for (int i = 0; i < 2; i++)
         db_rise[i] = sync2[i] & ~db_level[i] & (db_cnt[i] == CNT_LAST);
   end

   always_comb begin
      pend_nx = pend;
      if (state == S_LOAD) pend_nx[op_g2b] = 1'b0;
      pend_nx = pend_nx | db_rise;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      busy     = (state != S_IDLE);
      done     = 1'b0;
      case (state)
         S_IDLE:      if (pend != 2'b00) state_nx = S_LOAD;
         S_LOAD:      state_nx = op_g2b ? S_G2B_SHIFT : S_B2G_CALC;
         S_B2G_CALC:  state_nx = S_DONE;
         S_G2B_SHIFT: if (idx == '0) state_nx = S_DONE;
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default:     state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge btn_rst_n) begin
      if (!btn_rst_n) state <= S_IDLE;
      else            state <= state_nx;
   end

   // result_shr[i] is result[i+1], and 0 above the MSB.
   assign result_shr = result >> 1;

   always_comb begin
      result_nx = result;
      if (state == S_B2G_CALC)  result_nx = operand ^ (operand >> 1);
      if (state == S_G2B_SHIFT) result_nx[idx] = operand[idx] ^ result_shr[idx];
   end

   // NOTE: datapath registers are reset too, so nothing stale can reach led after reset.
   always_ff @(posedge clk or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         pend    <= '0;
         op_g2b  <= 1'b0;
         operand <= '0;
         result  <= '0;
         idx     <= '0;
         led     <= '0;
      end else begin
         pend   <= pend_nx;
         result <= result_nx;
         if (state == S_IDLE) op_g2b <= ~pend[0];
         if (state == S_LOAD) begin
            operand <= sw;
            idx     <= IDX_MSB;
         end
         if (state == S_G2B_SHIFT) idx <= idx - IDX_W'(1);
         // led is loaded on entry to DONE so it is valid during the done pulse.
         if (state_nx == S_DONE) led <= result_nx;
      end
   end

endmodule

// File: tb/tb_btn_conv_sequencer.sv
// Self-checking bench for btn_conv_sequencer: fixed vectors, random conversions
// against a Gray/binary model, and hand-written multi-cycle corner sequences.
module tb_btn_conv_sequencer;

   localparam int W  = 4;
   localparam int DB = 16;

   logic         clk = 1'b0;
   logic         btn_rst_n;
   logic [W-1:0] sw;
   logic         btn_b2g, btn_g2b;
   logic [W-1:0] led;
   logic         busy, done;

   btn_conv_sequencer #(.WIDTH(W), .DB_CYCLES(DB)) dut (
      .clk(clk), .btn_rst_n(btn_rst_n), .sw(sw), .btn_b2g(btn_b2g),
      .btn_g2b(btn_g2b), .led(led), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           op;
      logic [W-1:0] sw;
      logic [W-1:0] exp_led;
      int           exp_busy;
   } vec_t;

   int n_checks = 0, n_pass = 0;
   int done_cnt = 0, busy_cnt = 0, led_glitch = 0, bad_done = 0;
   logic [W-1:0] led_prev = '0;
   logic         rst_prev = 1'b0;

   // Observes every cycle: done pulses, busy cycles, led changes outside done.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && busy !== 1'b1) bad_done++;
      if (btn_rst_n && rst_prev && led !== led_prev && done !== 1'b1) led_glitch++;
      led_prev = led;
      rst_prev = btn_rst_n;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [W-1:0] to_bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      logic [W-1:0] hi;
      for (int i = 0; i < W; i++) begin
         hi   = g >> i;
         b[i] = ^hi;
      end
      return b;
   endfunction

   task automatic run_conv(input bit op, input logic [W-1:0] swv,
                           input logic [W-1:0] exp_led, input int exp_busy,
                           input string tag);
      int d0;
      int k;
      sw = swv;
      d0 = done_cnt;
      if (op) btn_g2b = 1'b1;
      else    btn_b2g = 1'b1;
      k = 0;
      while (busy !== 1'b1 && k < 4 * DB) begin
         tick(1);
         k++;
      end
      check({tag, " latency_in_window"}, int'(k >= DB + 2 && k <= DB + 5), 1);
      k = 0;
      while (busy === 1'b1 && k < 4 * W + 10) begin
         tick(1);
         k++;
      end
      check({tag, " busy_cycles"}, k, exp_busy);
      btn_b2g = 1'b0;
      btn_g2b = 1'b0;
      tick(DB + 6);
      check({tag, " led"}, int'(led), int'(exp_led));
      check({tag, " done_pulses"}, done_cnt - d0, 1);
   endtask

   task automatic wait_busy(input logic lvl, input int bound, input string tag);
      int k;
      k = 0;
      while (busy !== lvl && k < bound) begin
         tick(1);
         k++;
      end
      check({tag, " wait_busy"}, int'(busy === lvl), 1);
   endtask

   initial begin
      vec_t         tbl [8];
      bit           op;
      logic [W-1:0] s;
      int           d0, b0;
      logic [W-1:0] led0;

      tbl[0] = '{1'b0, 4'b1011, 4'b1110, 3};
      tbl[1] = '{1'b1, 4'b1110, 4'b1011, W + 2};
      tbl[2] = '{1'b0, 4'b1111, 4'b1000, 3};
      tbl[3] = '{1'b1, 4'b1000, 4'b1111, W + 2};
      tbl[4] = '{1'b0, 4'b0000, 4'b0000, 3};
      tbl[5] = '{1'b1, 4'b0001, 4'b0001, W + 2};
      tbl[6] = '{1'b1, 4'b1101, 4'b1001, W + 2};
      tbl[7] = '{1'b0, 4'b0100, 4'b0110, 3};

      btn_rst_n = 1'b0;
      btn_b2g   = 1'b0;
      btn_g2b   = 1'b0;
      sw        = '0;
      tick(3);
      check("reset led", int'(led), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      btn_rst_n = 1'b1;
      tick(2);

      for (int i = 0; i < 8; i++)
         run_conv(tbl[i].op, tbl[i].sw, tbl[i].exp_led, tbl[i].exp_busy,
                  $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         op = 1'($urandom_range(0, 1));
         s  = W'($urandom_range(0, (1 << W) - 1));
         run_conv(op, s, op ? to_bin(s) : to_gray(s), op ? W + 2 : 3,
                  $sformatf("rnd%0d", i));
      end

      // Simultaneous requests: b2g first, then g2b on the switch value at its LOAD.
      sw      = 4'b0110;
      d0      = done_cnt;
      btn_b2g = 1'b1;
      btn_g2b = 1'b1;
      wait_busy(1'b1, 4 * DB, "both first_start");
      wait_busy(1'b0, 20, "both first_end");
      check("both first_led", int'(led), int'(to_gray(4'b0110)));
      sw = 4'b0111;
      tick(1);
      check("both back_to_back_load", int'(busy), 1);
      wait_busy(1'b0, 20, "both second_end");
      check("both second_led", int'(led), int'(to_bin(4'b0111)));
      btn_b2g = 1'b0;
      btn_g2b = 1'b0;
      tick(DB + 6);
      check("both done_pulses", done_cnt - d0, 2);

      // Bounce shorter than the debounce window must never register.
      d0   = done_cnt;
      b0   = busy_cnt;
      led0 = led;
      sw   = 4'b0011;
      for (int i = 0; i < 10; i++) begin
         btn_g2b = 1'b1;
         tick(DB - 2);
         btn_g2b = 1'b0;
         tick(3);
      end
      tick(DB + 6);
      check("bounce busy_cycles", busy_cnt - b0, 0);
      check("bounce done_pulses", done_cnt - d0, 0);
      check("bounce led_held", int'(led), int'(led0));
      run_conv(1'b1, 4'b0011, to_bin(4'b0011), W + 2, "clean_after_bounce");

      // Two raw g2b presses around an in-flight b2g merge into one request.
      sw      = 4'b1010;
      d0      = done_cnt;
      b0      = busy_cnt;
      btn_b2g = 1'b1;
      btn_g2b = 1'b1;
      tick(1);
      btn_g2b = 1'b0;
      tick(1);
      btn_g2b = 1'b1;
      tick(DB + 24);
      btn_b2g = 1'b0;
      btn_g2b = 1'b0;
      tick(DB + 6);
      check("merge done_pulses", done_cnt - d0, 2);
      check("merge busy_cycles", busy_cnt - b0, 3 + W + 2);
      check("merge led", int'(led), int'(to_bin(4'b1010)));

      // Reset in G2B_SHIFT at index 1 with b2g pending.
      sw      = 4'b1110;
      btn_g2b = 1'b1;
      tick(2);
      btn_b2g = 1'b1;
      wait_busy(1'b1, 4 * DB, "rst load");
      tick(3);
      check("rst pre_busy", int'(busy), 1);
      btn_rst_n = 1'b0;
      #1;
      check("rst led", int'(led), 0);
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      btn_b2g = 1'b0;
      btn_g2b = 1'b0;
      tick(3);
      btn_rst_n = 1'b1;
      d0 = done_cnt;
      b0 = busy_cnt;
      tick(3 * DB);
      check("post_rst busy_cycles", busy_cnt - b0, 0);
      check("post_rst done_pulses", done_cnt - d0, 0);
      check("post_rst led", int'(led), 0);

      check("led_only_changes_with_done", led_glitch, 0);
      check("done_only_while_busy", bad_done, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
